// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, MDU results are queued
// and drained in idle slots, with a starvation-forced one-cycle WB stall.
module wb_wa_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        pop,
  input  logic        squash,
  input  logic [4:0]  squash_reg,
  input  logic [4:0]  wr_reg,
  input  logic [31:0] wr_data,
  output logic        vld,
  output logic [4:0]  rg,
  output logic [31:0] dat
);
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      rg  <= '0;
      dat <= '0;
    end else if (wr) begin
      // a same-cycle WB write to the same register is younger, so squash on entry
      vld <= !(squash && wr_reg == squash_reg);
      rg  <= wr_reg;
      dat <= wr_data;
    end else if (pop) begin
      vld <= 1'b0;
    end else if (squash && rg == squash_reg) begin
      vld <= 1'b0;
    end
  end
endmodule

module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_RegWrite,
  input  logic [4:0]               wb_WriteReg,
  input  logic [31:0]              wb_WriteData,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_reg,
  input  logic [31:0]              mdu_data,
  output logic                     stall_wb,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   buf_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count, count_nxt;
  logic [SW-1:0]              starve, starve_nxt;
  logic [DEPTH-1:0]           e_vld;
  logic [DEPTH-1:0][4:0]      e_reg;
  logic [DEPTH-1:0][31:0]     e_data;
  logic                       enq, wb_req, grant_wb, grant_head, pop, nonempty;

  assign buf_count  = count;
  assign mdu_ready  = count < CW'(DEPTH);
  assign nonempty   = count != '0;
  assign enq        = mdu_valid && mdu_ready && mdu_reg != 5'd0;
  assign wb_req     = wb_RegWrite && wb_WriteReg != 5'd0;
  // a stalled WB request is ignored entirely: no write, no squash
  assign grant_wb   = !stall_wb && wb_req;
  assign grant_head = (stall_wb || !wb_req) && nonempty;
  assign pop        = grant_head;

  always_comb begin
    count_nxt  = count + CW'(enq) - CW'(pop);
    starve_nxt = (grant_head || !nonempty) ? '0 : starve + 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    wb_wa_entry u_ent (
      .clk        (clk),
      .reset      (reset),
      .wr         (enq && tail == PW'(i)),
      .pop        (pop && head == PW'(i)),
      .squash     (grant_wb),
      .squash_reg (wb_WriteReg),
      .wr_reg     (mdu_reg),
      .wr_data    (mdu_data),
      .vld        (e_vld[i]),
      .rg         (e_reg[i]),
      .dat        (e_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      starve   <= '0;
      stall_wb <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count_nxt;
      if (starve_nxt == SW'(STARVE_LIMIT)) begin
        stall_wb <= 1'b1;
        starve   <= '0;
      end else begin
        stall_wb <= 1'b0;
        starve   <= starve_nxt;
      end
      if (grant_wb) begin
        rf_we    <= 1'b1;
        rf_waddr <= wb_WriteReg;
        rf_wdata <= wb_WriteData;
      end else if (grant_head) begin
        // squashed heads are popped silently; address/data keep their last values
        rf_we <= e_vld[head];
        if (e_vld[head]) begin
          rf_waddr <= e_reg[head];
          rf_wdata <= e_data[head];
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of the arbiter.
module tb_wb_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_WriteReg;
  logic [31:0] wb_WriteData;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  buf_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          v;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_WriteData(wb_WriteData),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .stall_wb(stall_wb), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_RegWrite = 0; wb_WriteReg = 0; wb_WriteData = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    tests++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata, buf_count, mdu_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 2'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got st=%b we=%b a=%0d d=%h cnt=%0d rdy=%b exp 0 0 0 0 0 1",
               stall_wb, rf_we, rf_waddr, rf_wdata, buf_count, mdu_ready);
    end
  endtask

  task automatic test_wb_only();
    do_reset();
    wb_RegWrite = 1; wb_WriteReg = 5; wb_WriteData = 32'hDEADBEEF;
    tick();
    wb_RegWrite = 1; wb_WriteReg = 0; wb_WriteData = 32'h11111111;
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd0}) begin
      fails++;
      $display("FAIL wb_write got we=%b a=%0d d=%h cnt=%0d exp 1 5 deadbeef 0", rf_we, rf_waddr, rf_wdata, buf_count);
    end
    tick();
    idle();
    tests++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL wb_reg0 got we=%b a=%0d d=%h exp 0 5 deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_idle_drain();
    do_reset();
    mdu_valid = 1; mdu_reg = 8; mdu_data = 32'h12345678;
    tick();
    mdu_valid = 0;
    tests++;
    if ({rf_we, buf_count} !== {1'b0, 2'd1}) begin
      fails++;
      $display("FAIL drain_queued got we=%b cnt=%0d exp 0 1", rf_we, buf_count);
    end
    tick();
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd8, 32'h12345678, 2'd0}) begin
      fails++;
      $display("FAIL drain_write got we=%b a=%0d d=%h cnt=%0d exp 1 8 12345678 0", rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wb_RegWrite = 1; wb_WriteReg = 3; wb_WriteData = 32'h33;
    mdu_valid = 1; mdu_reg = 10; mdu_data = 32'hA0;
    tick();
    mdu_reg = 11; mdu_data = 32'hA1;
    tick();
    mdu_reg = 12; mdu_data = 32'hA2;
    tests++;
    if ({mdu_ready, buf_count} !== {1'b0, 2'd2}) begin
      fails++;
      $display("FAIL bp_full got rdy=%b cnt=%0d exp 0 2", mdu_ready, buf_count);
    end
    tick();
    tests++;
    if ({mdu_ready, buf_count, rf_we, rf_waddr} !== {1'b0, 2'd2, 1'b1, 5'd3}) begin
      fails++;
      $display("FAIL bp_held got rdy=%b cnt=%0d we=%b a=%0d exp 0 2 1 3", mdu_ready, buf_count, rf_we, rf_waddr);
    end
    wb_RegWrite = 0;
    tick();
    tests++;
    if ({buf_count, rf_we, rf_waddr, rf_wdata, mdu_ready} !== {2'd1, 1'b1, 5'd10, 32'hA0, 1'b1}) begin
      fails++;
      $display("FAIL bp_pop1 got cnt=%0d we=%b a=%0d d=%h rdy=%b exp 1 1 10 a0 1", buf_count, rf_we, rf_waddr, rf_wdata, mdu_ready);
    end
    tick();
    mdu_valid = 0;
    tests++;
    if ({buf_count, rf_we, rf_waddr, rf_wdata} !== {2'd1, 1'b1, 5'd11, 32'hA1}) begin
      fails++;
      $display("FAIL bp_pop2 got cnt=%0d we=%b a=%0d d=%h exp 1 1 11 a1", buf_count, rf_we, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if ({buf_count, rf_we, rf_waddr, rf_wdata, stall_wb} !== {2'd0, 1'b1, 5'd12, 32'hA2, 1'b0}) begin
      fails++;
      $display("FAIL bp_pop3 got cnt=%0d we=%b a=%0d d=%h st=%b exp 0 1 12 a2 0", buf_count, rf_we, rf_waddr, rf_wdata, stall_wb);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    mdu_valid = 1; mdu_reg = 20; mdu_data = 32'hA5;
    for (int i = 0; i < 5; i++) begin
      wb_RegWrite = 1; wb_WriteReg = 5'(i + 1); wb_WriteData = 32'h100 + i;
      tick();
      mdu_valid = 0;
      tests++;
      if ({stall_wb, rf_we, rf_waddr, rf_wdata, buf_count} !== {(i == 4), 1'b1, 5'(i + 1), 32'h100 + i, 2'd1}) begin
        fails++;
        $display("FAIL starve_deny%0d got st=%b we=%b a=%0d d=%h cnt=%0d exp st=%b 1 %0d %h 1",
                 i, stall_wb, rf_we, rf_waddr, rf_wdata, buf_count, (i == 4), i + 1, 32'h100 + i);
      end
    end
    wb_WriteReg = 6; wb_WriteData = 32'h105;
    tick();
    tests++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b0, 1'b1, 5'd20, 32'hA5, 2'd0}) begin
      fails++;
      $display("FAIL starve_head got st=%b we=%b a=%0d d=%h cnt=%0d exp 0 1 20 a5 0", stall_wb, rf_we, rf_waddr, rf_wdata, buf_count);
    end
    tick();
    idle();
    tests++;
    if ({stall_wb, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd6, 32'h105}) begin
      fails++;
      $display("FAIL starve_replay got st=%b we=%b a=%0d d=%h exp 0 1 6 105", stall_wb, rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_squash();
    do_reset();
    wb_RegWrite = 1; wb_WriteReg = 2; wb_WriteData = 32'h22;
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h1;
    tick();
    mdu_valid = 0;
    wb_WriteReg = 9; wb_WriteData = 32'h2;
    tick();
    wb_RegWrite = 0;
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b1, 5'd9, 32'h2, 2'd1}) begin
      fails++;
      $display("FAIL squash_wb got we=%b a=%0d d=%h cnt=%0d exp 1 9 2 1", rf_we, rf_waddr, rf_wdata, buf_count);
    end
    tick();
    tests++;
    if ({rf_we, rf_waddr, rf_wdata, buf_count} !== {1'b0, 5'd9, 32'h2, 2'd0}) begin
      fails++;
      $display("FAIL squash_pop got we=%b a=%0d d=%h cnt=%0d exp 0 9 2 0", rf_we, rf_waddr, rf_wdata, buf_count);
    end
  endtask

  task automatic test_reset_midflow();
    do_reset();
    wb_RegWrite = 1; wb_WriteReg = 4; wb_WriteData = 32'h44;
    mdu_valid = 1; mdu_reg = 13; mdu_data = 32'hC0;
    tick();
    mdu_reg = 14; mdu_data = 32'hC1;
    tick();
    mdu_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    tests++;
    if ({buf_count, rf_we, stall_wb, mdu_ready} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid got cnt=%0d we=%b st=%b rdy=%b exp 0 0 0 1", buf_count, rf_we, stall_wb, mdu_ready);
    end
    idle();
    tick();
    tests++;
    if ({buf_count, rf_we} !== {2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_discard got cnt=%0d we=%b exp 0 0", buf_count, rf_we);
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    int          s, n;
    bit          m_stall, m_we, rdy, enq, wbq, gw, gh, acc_last;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    do_reset();
    s = 0; m_stall = 0; m_we = 0; m_addr = 0; m_data = 0; acc_last = 0;
    for (int c = 0; c < 600; c++) begin
      if (!stall_wb) begin
        wb_RegWrite  = ($urandom % 10) < 6;
        wb_WriteReg  = 5'($urandom % 8);
        wb_WriteData = $urandom;
      end
      if (!(mdu_valid && !acc_last)) begin
        mdu_valid = $urandom % 2;
        mdu_reg   = 5'($urandom % 8);
        mdu_data  = $urandom;
      end
      reset = ($urandom % 64) == 0;
      n   = q.size();
      rdy = n < DEPTH;
      tests++;
      if (mdu_ready !== rdy) begin
        fails++;
        $display("FAIL rnd_ready cyc %0d got %b exp %b", c, mdu_ready, rdy);
      end
      enq = mdu_valid && rdy && mdu_reg != 0;
      wbq = wb_RegWrite && wb_WriteReg != 0;
      gw  = !m_stall && wbq;
      gh  = (m_stall || !wbq) && n > 0;
      acc_last = mdu_valid && rdy && !reset;
      if (reset) begin
        q.delete(); s = 0; m_stall = 0; m_we = 0; m_addr = 0; m_data = 0;
      end else begin
        if (gw) begin
          foreach (q[k]) if (q[k].r == wb_WriteReg) q[k].v = 0;
          m_we = 1; m_addr = wb_WriteReg; m_data = wb_WriteData;
        end else if (gh) begin
          m_we = q[0].v;
          if (q[0].v) begin m_addr = q[0].r; m_data = q[0].d; end
          void'(q.pop_front());
        end else begin
          m_we = 0;
        end
        if (enq) q.push_back('{!(gw && mdu_reg == wb_WriteReg), mdu_reg, mdu_data});
        if (gh || n == 0) s = 0; else s++;
        if (s == LIMIT) begin m_stall = 1; s = 0; end else m_stall = 0;
      end
      tick();
      reset = 0;
      tests++;
      if ({stall_wb, rf_we, rf_waddr, rf_wdata, buf_count} !== {m_stall, m_we, m_addr, m_data, 2'(q.size())}) begin
        fails++;
        $display("FAIL rnd_out cyc %0d got st=%b we=%b a=%0d d=%h cnt=%0d exp st=%b we=%b a=%0d d=%h cnt=%0d",
                 c, stall_wb, rf_we, rf_waddr, rf_wdata, buf_count, m_stall, m_we, m_addr, m_data, q.size());
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_wb_only();
    test_idle_drain();
    test_backpressure();
    test_starvation();
    test_squash();
    test_reset_midflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Owns the single register-file write port. Shares it between the pipeline WRITEBACK stage result and the asynchronous multiply/divide unit (MDU) result.
- The pipeline has priority. MDU results are buffered in a small FIFO and drained in idle WB slots.
- A starvation counter forces a one-cycle WB stall so buffered results are guaranteed to retire.
- Sits between the WB stage mux output, the MDU result interface and the register file.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive denied cycles with non-empty FIFO before a forced stall (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
wb_RegWrite  input  1  WB stage requests register write
wb_WriteReg  input  5  WB destination register
wb_WriteData  input  32  WB write data (MemtoReg mux output)
mdu_valid  input  1  MDU result available
mdu_ready  output  1  arbiter can accept an MDU result
mdu_reg  input  5  MDU destination register
mdu_data  input  32  MDU result data
stall_wb  output  1  pipeline must hold WB contents this cycle
rf_we  output  1  register file write enable
rf_waddr  output  5  register file write address
rf_wdata  output  32  register file write data
buf_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: synchronous, active-high; clk and reset are the only clock/reset. On reset, at the clock edge:
  - FIFO emptied; all entry valid bits cleared.
  - Starvation counter = 0.
  - stall_wb = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, buf_count = 0.
  - Reset mid-operation discards buffered results; no write is issued in the reset cycle.
- mdu_ready:
  - Equals buf_count < DEPTH, from registered state only. It does not depend on a same-cycle pop, so a full FIFO never accepts, even while popping.
- Accept:
  - Accept occurs when mdu_valid && mdu_ready.
  - mdu_reg == 0: handshake completes but the result is dropped and not enqueued.
  - Otherwise: {valid=1, reg, data} is written at the tail.
- Grant per cycle (combinational, priority order):
  1. stall_wb == 1: grant the FIFO head.
  2. wb_RegWrite && wb_WriteReg != 0: grant WB.
  3. buf_count > 0: grant the FIFO head.
  4. Otherwise: no grant.
- WB writes to register 0 are never issued.
- Write port:
  - Registered with one-cycle latency. The grant in cycle N appears on rf_* in cycle N+1.
  - rf_we is set only for WB grants and for valid head entries; otherwise rf_we = 0.
  - rf_waddr and rf_wdata hold their last values when rf_we = 0.
- Pop:
  - A head grant pops one entry, even if that entry is invalid (squashed).
- Squash:
  - When WB is granted, every buffered entry with reg == wb_WriteReg has its valid bit cleared.
  - Reason: the pipeline write is younger in program order.
  - An entry enqueued in the same cycle with a matching reg is also squashed.
- buf_count:
  - Next value = count + accept(enqueued) - pop.
  - Simultaneous enqueue and pop leaves the count unchanged.
  - Squashed entries still count until popped.
  - Head and tail pointers wrap modulo DEPTH.
- Starvation:
  - The counter increments each cycle in which buf_count > 0 and the head is not granted.
  - It clears whenever the head is granted or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_wb is registered high for exactly one cycle and the counter clears.
  - stall_wb is never high for two consecutive cycles.
- Stalled WB: during a stall_wb cycle, the WB request is not written and is not used for squash. The pipeline re-presents it the next cycle.

Test Plan:
- Reset mid-flow: FIFO holds 2 entries, assert reset 1 cycle -> next cycle buf_count=0, rf_we=0, stall_wb=0, mdu_ready=1.
- WB only: wb_RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Repeat with WriteReg=0 -> rf_we=0.
- Idle drain: MDU pushes reg 8 = 0x12345678 with WB idle -> buf_count=1 for one cycle, then rf_we=1, waddr=8, wdata=0x12345678, buf_count=0.
- Full/backpressure: WB busy, MDU pushes 3 results -> mdu_ready=0 after 2 accepts, buf_count=2, third result held by MDU until a pop.
- Starvation: WB writes every cycle with FIFO non-empty, STARVE_LIMIT=4 -> stall_wb=1 for exactly one cycle after 4 denied cycles. The head is written the following cycle, and the held WB write completes the cycle after that.
- Squash: FIFO holds reg 9 = 0x1, then WB writes reg 9 = 0x2 -> the later head pop gives rf_we=0. The final value of reg 9 is 0x2, and buf_count decrements.
